// File: rtl/seq_mult_pkg.sv
// Shared types and default sizing for the sequential signed multiplier.
// Consumers: seq_mult_ctrl and its accumulator register.
package seq_mult_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_PW    = 2 * (DEF_WIDTH - 1);
    localparam int DEF_ITER  = DEF_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CALC   = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/seq_mult_ctrl_acc.sv
// Enabled product accumulator register. It has no reset: the controller
// clears it with a zero load before every multiplication.
module seq_mult_ctrl_acc
    import seq_mult_pkg::*;
#(
    parameter int PW = DEF_PW
)
(
    input  logic          clk,
    input  logic          en,
    input  logic [PW-1:0] d,
    output logic [PW-1:0] q
);

    always_ff @(posedge clk) begin
        if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencer for a sign-magnitude shift-add signed multiplier.
// Build option SEQ_MULT_EARLY_TERM_EN stops the loop once the multiplier runs out of set bits.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2*WIDTH-1:0] result
);

    localparam int MW   = WIDTH - 1;
    localparam int PW   = 2 * MW;
    localparam int ITER = WIDTH - 1;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {MW{1'b0}}};

    // Handshake: start is taken only on an edge where busy is low; every
    // accepted request yields exactly one done pulse, and result/err stay
    // stable from that pulse until the next accept (err) or done (result).

    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q;
    logic [PW-1:0]    mcand;
    logic [MW-1:0]    mplier;
    logic             sign;
    logic [CW-1:0]    count;
    logic             err_pend;

    logic [PW-1:0]    acc_q, acc_d;
    logic             acc_en;

    logic [MW-1:0]    a_mag, b_mag;
    logic             a_min, b_min;
    logic [MW-1:0]    mplier_shr;
    logic             last_iter;
    logic [PW:0]      prod_mag, prod_signed;
    logic [2*WIDTH-1:0] result_next;

    assign a_min      = (a_q == MIN_VAL);
    assign b_min      = (b_q == MIN_VAL);
    assign a_mag      = a_q[WIDTH-1] ? (~a_q[MW-1:0] + MW'(1)) : a_q[MW-1:0];
    assign b_mag      = b_q[WIDTH-1] ? (~b_q[MW-1:0] + MW'(1)) : b_q[MW-1:0];
    assign mplier_shr = mplier >> 1;
    assign last_iter  = (count == CW'(ITER - 1));

    // A zero accumulator is never negated, so no negative zero can appear.
    assign prod_mag    = {1'b0, acc_q};
    assign prod_signed = (sign && (acc_q != '0)) ? (~prod_mag + (PW+1)'(1)) : prod_mag;
    assign result_next = {prod_signed[PW], prod_signed};

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_en     = 1'b0;
        acc_d      = acc_q + mcand;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                acc_en     = 1'b1;
                acc_d      = '0;
                state_next = CALC;
`ifdef SEQ_MULT_EARLY_TERM_EN
                if (b_mag == '0) begin
                    state_next = FINISH;
                end
`endif
                if (a_min || b_min) begin
                    state_next = FINISH;
                end
            end
            CALC: begin
                acc_en = mplier[0];
                if (last_iter) begin
                    state_next = FINISH;
                end
`ifdef SEQ_MULT_EARLY_TERM_EN
                if (mplier_shr == '0) begin
                    state_next = FINISH;
                end
`endif
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            sign     <= 1'b0;
            count    <= '0;
            err_pend <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                        err <= 1'b0;
                    end
                end
                LOAD: begin
                    mcand    <= {{(PW-MW){1'b0}}, a_mag};
                    mplier   <= b_mag;
                    sign     <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                    count    <= '0;
                    err_pend <= a_min || b_min;
                end
                CALC: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier_shr;
                    count  <= count + CW'(1);
                end
                FINISH: begin
                    done   <= 1'b1;
                    err    <= err_pend;
                    result <= err_pend ? '0 : result_next;
                end
                default: begin
                end
            endcase
        end
    end

    seq_mult_ctrl_acc #(.PW(PW)) u_acc (
        .clk (clk),
        .en  (acc_en),
        .d   (acc_d),
        .q   (acc_q)
    );

endmodule
